// File: rtl/core_pkg.sv
// core_pkg: shared core constants and the fetch queue entry type.
package core_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: imem request/response, redirect and decode-side handshake bundle.
interface instr_fetch_queue_if #(parameter int DEPTH = 4);
  import core_pkg::*;
  logic imem_req_valid;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output imem_req_valid, imem_addr, out_valid, out_instr, out_pc, count,
    input imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input imem_req_valid, imem_addr, out_valid, out_instr, out_pc, count,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: registered-storage FIFO with push/pop/flush and occupancy flags.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o = cnt_q == CW'(DEPTH);
    do_pop = pop_i && !empty_o;
    rdata_o = mem_q[rd_q];
    count_o = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential fetch with credit-limited issue to a 1-cycle ROM,
// buffering {pc, instr} for decode; redirect flushes and restarts fetch.
module instr_fetch_queue import core_pkg::*; #(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic clk,
  input logic reset,
  instr_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic inflight_q, inflight_d;
  logic req, push, pop, empty, full;
  logic [CW-1:0] count;
  fetch_entry_t head, wentry;
  always_comb begin
    // outstanding request holds a credit, so the response always has room
    req = reset && !bus.redirect_valid && (int'(count) + int'(inflight_q) < DEPTH);
    push = inflight_q && !bus.redirect_valid;
    bus.out_valid = !empty && !bus.redirect_valid;
    pop = bus.out_valid && bus.out_ready;
    fetch_pc_d = bus.redirect_valid ? (bus.redirect_pc & ~XLEN'(INSTR_BYTES-1))
               : req ? fetch_pc_q + XLEN'(INSTR_BYTES) : fetch_pc_q;
    inflight_d = req;
    req_pc_d = req ? fetch_pc_q : req_pc_q;
    wentry = '{pc: req_pc_q, instr: bus.imem_rdata};
    bus.imem_req_valid = req;
    bus.imem_addr = fetch_pc_q;
    bus.out_instr = bus.out_valid ? head.instr : NOP_INSTR;
    bus.out_pc = bus.out_valid ? head.pc : '0;
    bus.count = count;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end
  always_ff @(posedge clk)
    if (reset && push) assert (!full) else $error("fetch queue overflow");
  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .pop_i(pop),
    .flush_i(bus.redirect_valid),
    .wdata_i(wentry),
    .rdata_o(head),
    .count_o(count),
    .empty_o(empty),
    .full_o(full)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed and random stimulus checked against a queue-based model.
module tb_instr_fetch_queue;
  import core_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  instr_fetch_queue_if #(.DEPTH(DEPTH)) bus();
  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction
  logic [31:0] rom_a;
  logic rom_v;
  always @(posedge clk) begin
    rom_a <= bus.imem_addr;
    rom_v <= bus.imem_req_valid;
  end
  assign bus.imem_rdata = rom_v ? rom(rom_a) : 32'hDEAD_BEEF;
  int errors = 0;
  int checks = 0;
  ent_t mq[$];
  logic [31:0] m_fpc, m_ipc;
  bit m_inf, m_ok;
  logic s_req, s_ov;
  logic [31:0] s_addr, s_pc, s_ins, s_cnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit e_req, e_ov;
    logic [31:0] e_pc, e_ins;
    @(negedge clk);
    reset = rst;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.out_ready = rdy;
    #1;
    s_req = bus.imem_req_valid;
    s_addr = bus.imem_addr;
    s_ov = bus.out_valid;
    s_pc = bus.out_pc;
    s_ins = bus.out_instr;
    s_cnt = 32'(bus.count);
    e_req = rst && !rv && (mq.size() + int'(m_inf) < DEPTH);
    e_ov = mq.size() != 0 && !rv;
    e_pc = 32'h0;
    e_ins = NOP_INSTR;
    if (e_ov) begin
      e_pc = mq[0].pc;
      e_ins = mq[0].ins;
    end
    if (m_ok) begin
      chk("req", 32'(s_req), 32'(e_req));
      chk("addr", s_addr, m_fpc);
      chk("out_valid", 32'(s_ov), 32'(e_ov));
      chk("out_pc", s_pc, e_pc);
      chk("out_instr", s_ins, e_ins);
      chk("count", s_cnt, 32'(mq.size()));
    end
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_fpc = RPC;
      m_inf = 1'b0;
      m_ok = 1'b1;
    end else if (rv) begin
      mq.delete();
      m_fpc = rpc & ~32'h3;
      m_inf = 1'b0;
    end else begin
      if (e_ov && rdy) void'(mq.pop_front());
      if (m_inf) mq.push_back('{m_ipc, rom(m_ipc)});
      if (e_req) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
      m_inf = e_req;
    end
  endtask
  initial begin
    int n;
    m_ok = 1'b0;
    m_inf = 1'b0;
    m_fpc = RPC;
    m_ipc = RPC;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      if (i == 0) begin
        chk("a_c0_addr", s_addr, RPC);
        chk("a_c0_req", 32'(s_req), 32'd1);
      end
      if (i == 1) chk("a_c1_out_valid", 32'(s_ov), 32'd0);
      if (i == 2) begin
        chk("a_c2_out_valid", 32'(s_ov), 32'd1);
        chk("a_c2_out_pc", s_pc, RPC);
        chk("a_c2_out_instr", s_ins, rom(RPC));
      end
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      n += int'(s_req);
    end
    chk("b_requests", 32'(n), 32'd4);
    chk("b_full_count", s_cnt, 32'd4);
    chk("b_req_stalled", 32'(s_req), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      if (i < 4) chk("b_drain_pc", s_pc, 32'(i * 4));
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, i == 5, 32'h1C, !(i == 4 || i == 5));
      if (i == 5) begin
        chk("c_c5_count", s_cnt, 32'd2);
        chk("c_c5_out_valid", 32'(s_ov), 32'd0);
      end
      if (i == 6) begin
        chk("c_c6_addr", s_addr, 32'h1C);
        chk("c_c6_count", s_cnt, 32'd0);
      end
      if (i == 7) chk("c_c7_out_valid", 32'(s_ov), 32'd0);
      if (i == 8) chk("c_c8_out_pc", s_pc, 32'h1C);
      if (i == 9) chk("c_c9_out_pc", s_pc, 32'h20);
    end
    cyc(1'b1, 1'b1, 32'h23, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("d_addr_aligned", s_addr, 32'h20);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("d_out_pc", s_pc, 32'h20);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("e_wrap_pc0", s_pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("e_wrap_pc1", s_pc, 32'h0000_0000);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("f_pre_count", s_cnt, 32'd3);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("f_count", s_cnt, 32'd0);
    chk("f_out_valid", 32'(s_ov), 32'd0);
    chk("f_out_instr", s_ins, 32'h13);
    chk("f_out_pc", s_pc, 32'h0);
    chk("f_addr", s_addr, RPC);
    chk("f_req", 32'(s_req), 32'd1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
          $urandom_range(0, 2) != 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
